// File: rtl/ethernet_sys_input_debounce.sv
// Input conditioning for the ethernet_sys input PIO: per-bit synchronizer, counter debounce,
// registered rise/fall event pulses and sticky write-1-to-clear edge capture.
module ethernet_sys_input_debounce #(
  parameter int unsigned     WIDTH           = 8,
  parameter int unsigned     SYNC_STAGES     = 2,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             change_any,
  output logic [WIDTH-1:0] edge_capture
);

  localparam int unsigned    CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;

  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]           deb_q, deb_d;
  logic [WIDTH-1:0]           rise_q, rise_d;
  logic [WIDTH-1:0]           fall_q, fall_d;
  logic [WIDTH-1:0]           cap_q, cap_d;

  // Stage 0 is the only register that sees raw_in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync[i] == deb_q[i]) begin
        // Any return to the accepted level restarts the qualification window.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        deb_d[i]  = sync[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync[i];
        fall_d[i] = ~sync[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
    // A new event outranks a simultaneous clear so no edge is ever lost.
    cap_d = (cap_q & ~edge_clear) | rise_d | fall_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      deb_q  <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
      cap_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cap_q  <= cap_d;
    end
  end

  assign debounced_out = deb_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign change_any    = |(rise_q | fall_q);
  assign edge_capture  = cap_q;

endmodule
